sync_fifo_flags: RTL

//  Single-clock, parametrised successor to the dual-clock FIFO for same-domain buffering.
//  - Binary pointers and an occupancy counter replace the gray/sync logic.
//  - Adds programmable almost-full/almost-empty levels, an occupancy count output,

---
 rtl/sync_fifo_flags_if.sv | 28 ++
 rtl/sync_fifo_flags.sv | 112 +++++++++++
 2 files changed

// File: rtl/sync_fifo_flags_if.sv
// Handshake bundle between a producer/consumer (master) and the single-clock FIFO (slave).
interface sync_fifo_flags_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                clr;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                wfull;
  logic                rempty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDRSIZE:0]   count;
  logic                overflow;
  logic                underflow;

  modport master (
    output clr, winc, wdata, rinc,
    input  rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, winc, wdata, rinc,
    output rdata, wfull, rempty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error
// flags, synchronous flush and an optional first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_flags_if.slave bus
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0]   DEPTH_C  = (ADDRSIZE + 1)'(DEPTH);
  localparam logic [ADDRSIZE:0]   AFULL_C  = (ADDRSIZE + 1)'(AFULL_LVL);
  localparam logic [ADDRSIZE:0]   AEMPTY_C = (ADDRSIZE + 1)'(AEMPTY_LVL);
  localparam logic [ADDRSIZE:0]   ZERO_C   = {(ADDRSIZE + 1){1'b0}};
  localparam logic [ADDRSIZE:0]   ONE_C    = (ADDRSIZE + 1)'(1);
  localparam logic [ADDRSIZE-1:0] PTR_ONE  = ADDRSIZE'(1);

  logic [DATASIZE-1:0] mem_r [DEPTH];
  logic [ADDRSIZE-1:0] waddr_r;
  logic [ADDRSIZE-1:0] raddr_r;
  logic [ADDRSIZE:0]   count_r;
  logic [ADDRSIZE:0]   count_nxt_s;
  logic                overflow_r;
  logic                underflow_r;
  logic                full_s;
  logic                empty_s;
  logic                wr_acc_s;
  logic                rd_acc_s;

  // Full/empty come only from the count; pointers alone cannot tell them apart.
  always_comb begin
    full_s   = (count_r == DEPTH_C);
    empty_s  = (count_r == ZERO_C);
    wr_acc_s = bus.winc & ~full_s  & ~bus.clr & ~rst;
    rd_acc_s = bus.rinc & ~empty_s & ~bus.clr & ~rst;
  end

  // Next occupancy: a simultaneous accepted read and write leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and sticky error state; flush behaves like reset here.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      waddr_r     <= {ADDRSIZE{1'b0}};
      raddr_r     <= {ADDRSIZE{1'b0}};
      count_r     <= ZERO_C;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        waddr_r <= waddr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        raddr_r <= raddr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      if (bus.winc && full_s) begin
        overflow_r <= 1'b1;
      end
      if (bus.rinc && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[waddr_r] <= bus.wdata;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdata = mem_r[raddr_r];
    end else begin : g_reg
      logic [DATASIZE-1:0] rdata_r;

      // Registered read port; flush deliberately keeps the last word.
      always_ff @(posedge clk) begin
        if (rst) begin
          rdata_r <= {DATASIZE{1'b0}};
        end else if (rd_acc_s) begin
          rdata_r <= mem_r[raddr_r];
        end
      end

      assign bus.rdata = rdata_r;
    end
  endgenerate

  assign bus.count        = count_r;
  assign bus.wfull        = full_s;
  assign bus.rempty       = empty_s;
  assign bus.almost_full  = (count_r >= AFULL_C);
  assign bus.almost_empty = (count_r <= AEMPTY_C);
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule
